wb_pipe: RTL and testbench



---
 rtl/wb_pipe_pkg.sv | 29 ++
 rtl/wb_pipe_load_align.sv | 60 ++++++
 rtl/wb_pipe.sv | 152 +++++++++++++++
 tb/tb_wb_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_pkg.sv
// Shared types for the hxd32 writeback stage: register-write source select,
// DRAM load operation codes and the writeback FSM state encoding.
package wb_pipe_pkg;

   // Source of the register-file write data. Code 2'd3 is unused.
   typedef enum logic [1:0] {
      RD_WR_ALU     = 2'd0,
      RD_WR_DRAM    = 2'd1,
      RD_WR_PC_NEXT = 2'd2
   } reg_op_enum;

   // DRAM load widths. Codes 0..4 are the original set. WU and D are appended
   // so existing encodings keep their values. Code 3'd7 is unused.
   typedef enum logic [2:0] {
      DRAM_RD_B  = 3'd0,
      DRAM_RD_H  = 3'd1,
      DRAM_RD_W  = 3'd2,
      DRAM_RD_BU = 3'd3,
      DRAM_RD_HU = 3'd4,
      DRAM_RD_WU = 3'd5,
      DRAM_RD_D  = 3'd6
   } ram_op_enum;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_pipe_load_align.sv
// Combinational load aligner: selects the addressed byte lane of a DRAM word,
// sign- or zero-extends it to XLEN and flags misaligned accesses.
module wb_load_align
   import wb_pipe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      sel_i,
   input  logic [2:0]      offset_i,
   input  logic [XLEN-1:0] raw_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);

   localparam logic [2:0] OFF_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

   logic [2:0]      off;
   logic [XLEN-1:0] shifted;

   // Shift the addressed lane down to bit 0, then extend by operation width.
   always_comb begin
      // NOTE: every output gets a default before the case, so no path can
      // leave a signal unassigned and infer a latch.
      data_o     = '0;
      misalign_o = 1'b0;
      off        = offset_i & OFF_MASK;
      shifted    = raw_i >> {off, 3'b000};
      case (ram_op_enum'(sel_i))
         DRAM_RD_B:  data_o = XLEN'(signed'(shifted[7:0]));
         DRAM_RD_BU: data_o = XLEN'(shifted[7:0]);
         DRAM_RD_H: begin
            data_o     = XLEN'(signed'(shifted[15:0]));
            misalign_o = off[0];
         end
         DRAM_RD_HU: begin
            data_o     = XLEN'(shifted[15:0]);
            misalign_o = off[0];
         end
         DRAM_RD_W: begin
            data_o     = XLEN'(signed'(shifted[31:0]));
            misalign_o = (off[1:0] != 2'b00);
         end
         // WU and D only exist on 64-bit cores; on 32-bit they load zero.
         DRAM_RD_WU: begin
            if (XLEN == 64) begin
               data_o     = XLEN'(shifted[31:0]);
               misalign_o = (off[1:0] != 2'b00);
            end
         end
         DRAM_RD_D: begin
            if (XLEN == 64) begin
               data_o     = shifted;
               misalign_o = (off != 3'b000);
            end
         end
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_pipe.sv
// Writeback stage: registers ALU/PC-next results, or waits for a DRAM read
// response and writes the aligned load value. Reports misaligned loads and
// loads that never receive a response.
module wb_pipe
   import wb_pipe_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            rd_wr_en_i,
   input  logic [4:0]      rd_wr_addr_i,
   input  logic [1:0]      rd_wr_sel_i,
   input  logic [XLEN-1:0] pc_next_i,
   input  logic [XLEN-1:0] alu_data_i,
   input  logic [2:0]      dram_rd_sel_i,
   input  logic [2:0]      dram_addr_i,
   input  logic            dram_rsp_valid_i,
   input  logic [XLEN-1:0] dram_rsp_data_i,
   output logic            rd_wr_en_o,
   output logic [4:0]      rd_wr_addr_o,
   output logic [XLEN-1:0] rd_wr_data_o,
   output logic            misalign_o,
   output logic            timeout_o
);

   localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

   wb_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_en_q, ld_en_d;
   logic [4:0]       ld_addr_q, ld_addr_d;
   logic [2:0]       ld_sel_q, ld_sel_d;
   logic [2:0]       ld_off_q, ld_off_d;
   logic             wr_en_q, wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]  wr_data_q, wr_data_d;
   logic             misalign_q, misalign_d;
   logic             timeout_q, timeout_d;

   logic [XLEN-1:0]  ld_data;
   logic             ld_misalign;

   wb_load_align #(.XLEN(XLEN)) u_align (
      .sel_i      (ld_sel_q),
      .offset_i   (ld_off_q),
      .raw_i      (dram_rsp_data_i),
      .data_o     (ld_data),
      .misalign_o (ld_misalign)
   );

   assign in_ready_o   = (state_q == IDLE);
   assign rd_wr_en_o   = wr_en_q;
   assign rd_wr_addr_o = wr_addr_q;
   assign rd_wr_data_o = wr_data_q;
   assign misalign_o   = misalign_q;
   assign timeout_o    = timeout_q;

   // Next-state and output logic: strobes default low, write data holds.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_en_d    = ld_en_q;
      ld_addr_d  = ld_addr_q;
      ld_sel_d   = ld_sel_q;
      ld_off_d   = ld_off_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               if (reg_op_enum'(rd_wr_sel_i) == RD_WR_DRAM) begin
                  ld_en_d   = rd_wr_en_i && (rd_wr_addr_i != 5'd0);
                  ld_addr_d = rd_wr_addr_i;
                  ld_sel_d  = dram_rd_sel_i;
                  ld_off_d  = dram_addr_i;
                  cnt_d     = '0;
                  state_d   = WAIT;
               end else begin
                  wr_en_d = rd_wr_en_i && (rd_wr_addr_i != 5'd0);
                  if (wr_en_d) begin
                     wr_addr_d = rd_wr_addr_i;
                     case (reg_op_enum'(rd_wr_sel_i))
                        RD_WR_ALU:     wr_data_d = alu_data_i;
                        RD_WR_PC_NEXT: wr_data_d = pc_next_i;
                        default:       wr_data_d = '0;
                     endcase
                  end
               end
            end
         end
         WAIT: begin
            if (dram_rsp_valid_i) begin
               state_d = IDLE;
               if (ld_misalign) begin
                  misalign_d = 1'b1;
               end else if (ld_en_q) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ld_addr_q;
                  wr_data_d = ld_data;
               end
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, load context and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ld_en_q    <= 1'b0;
         ld_addr_q  <= '0;
         ld_sel_q   <= '0;
         ld_off_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational block.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_en_q    <= ld_en_d;
         ld_addr_q  <= ld_addr_d;
         ld_sel_q   <= ld_sel_d;
         ld_off_q   <= ld_off_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: a 32-bit and a 64-bit instance share one stimulus
// stream. Both are checked against a transaction-level load model.
module tb_wb_pipe;
   import wb_pipe_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, rd_en, rsp_valid;
   logic [4:0]  rd_addr;
   logic [1:0]  rd_sel;
   logic [2:0]  ld_sel, ld_addr;
   logic [63:0] pc, alu, rsp_data;

   logic        rdy32, en32, mis32, to32, rdy64, en64, mis64, to64;
   logic [4:0]  a32, a64;
   logic [31:0] d32;
   logic [63:0] d64;

   logic        obs_rdy [2];
   logic        obs_en  [2];
   logic        obs_mis [2];
   logic        obs_to  [2];
   logic [4:0]  obs_addr[2];
   logic [63:0] obs_data[2];
   logic [4:0]  hold_addr[2];
   logic [63:0] hold_data[2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_pipe #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut32 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32),
      .rd_wr_en_i(rd_en), .rd_wr_addr_i(rd_addr), .rd_wr_sel_i(rd_sel),
      .pc_next_i(pc[31:0]), .alu_data_i(alu[31:0]), .dram_rd_sel_i(ld_sel),
      .dram_addr_i(ld_addr), .dram_rsp_valid_i(rsp_valid), .dram_rsp_data_i(rsp_data[31:0]),
      .rd_wr_en_o(en32), .rd_wr_addr_o(a32), .rd_wr_data_o(d32),
      .misalign_o(mis32), .timeout_o(to32)
   );

   wb_pipe #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut64 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy64),
      .rd_wr_en_i(rd_en), .rd_wr_addr_i(rd_addr), .rd_wr_sel_i(rd_sel),
      .pc_next_i(pc), .alu_data_i(alu), .dram_rd_sel_i(ld_sel),
      .dram_addr_i(ld_addr), .dram_rsp_valid_i(rsp_valid), .dram_rsp_data_i(rsp_data),
      .rd_wr_en_o(en64), .rd_wr_addr_o(a64), .rd_wr_data_o(d64),
      .misalign_o(mis64), .timeout_o(to64)
   );

   assign obs_rdy[0]  = rdy32;  assign obs_rdy[1]  = rdy64;
   assign obs_en[0]   = en32;   assign obs_en[1]   = en64;
   assign obs_mis[0]  = mis32;  assign obs_mis[1]  = mis64;
   assign obs_to[0]   = to32;   assign obs_to[1]   = to64;
   assign obs_addr[0] = a32;    assign obs_addr[1] = a64;
   assign obs_data[0] = {32'd0, d32};
   assign obs_data[1] = d64;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  addr;
      logic [63:0] rsp;
      int          k;      // response in the k-th WAIT cycle; 0 = never
      logic [63:0] e32;
      logic [63:0] e64;
      bit          m32;
      bit          m64;
   } vec_t;

   vec_t vecs[11];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare one instance (w: 0 = 32-bit, 1 = 64-bit); a write updates the held values.
   task automatic check_one(string tag, int w, bit rdy, bit en, bit mis, bit to,
                            logic [4:0] a, logic [63:0] d);
      string n;
      n = $sformatf("%s.x%0d", tag, (w == 0) ? 32 : 64);
      if (en) begin
         hold_addr[w] = a;
         hold_data[w] = (w == 0) ? (d & 64'hFFFF_FFFF) : d;
      end
      check({n, ".ready"},    64'(obs_rdy[w]), 64'(rdy));
      check({n, ".wr_en"},    64'(obs_en[w]),  64'(en));
      check({n, ".misalign"}, 64'(obs_mis[w]), 64'(mis));
      check({n, ".timeout"},  64'(obs_to[w]),  64'(to));
      check({n, ".addr"},     64'(obs_addr[w]), 64'(hold_addr[w]));
      check({n, ".data"},     obs_data[w],     hold_data[w]);
   endtask

   // Reference load: lane pick and extension from the rules, in plain arithmetic.
   function automatic logic [63:0] ref_load(int xlen, logic [2:0] op, logic [2:0] addr,
                                            logic [63:0] rsp, output bit mis);
      int          off, nbytes;
      bit          sgn;
      logic [63:0] v, word, mask;
      mis  = 1'b0;
      word = (xlen == 32) ? (rsp & 64'hFFFF_FFFF) : rsp;
      off  = (xlen == 64) ? int'(addr) : int'(addr) % 4;
      case (op)
         3'd0: begin nbytes = 1; sgn = 1; end
         3'd3: begin nbytes = 1; sgn = 0; end
         3'd1: begin nbytes = 2; sgn = 1; end
         3'd4: begin nbytes = 2; sgn = 0; end
         3'd2: begin nbytes = 4; sgn = 1; end
         3'd5: begin if (xlen == 32) return 64'd0; nbytes = 4; sgn = 0; end
         3'd6: begin if (xlen == 32) return 64'd0; nbytes = 8; sgn = 0; end
         default: return 64'd0;
      endcase
      if (off % nbytes != 0) begin
         mis = 1'b1;
         return 64'd0;
      end
      v = word >> (8 * off);
      if (nbytes < 8) begin
         mask = (64'd1 << (8 * nbytes)) - 64'd1;
         v    = v & mask;
         if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
      end
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic do_alu(string tag, logic [1:0] sel, bit en, logic [4:0] rd,
                         logic [63:0] a, logic [63:0] p);
      logic [63:0] exp;
      bit          we;
      in_valid  = 1'b1; rd_sel = sel; rd_en = en; rd_addr = rd; alu = a; pc = p;
      rsp_valid = 1'($urandom % 2); rsp_data = {$urandom, $urandom};
      ld_sel    = 3'($urandom); ld_addr = 3'($urandom);
      @(negedge clk);
      in_valid  = 1'b0; rsp_valid = 1'b0;
      exp = (sel == RD_WR_ALU) ? a : (sel == RD_WR_PC_NEXT) ? p : 64'd0;
      we  = en && (rd != 5'd0);
      for (int w = 0; w < 2; w++) check_one(tag, w, 1'b1, we, 1'b0, 1'b0, rd, (w == 0) ? exp : exp);
   endtask

   task automatic do_load(string tag, logic [2:0] op, logic [2:0] addr, logic [63:0] rsp,
                          bit en, logic [4:0] rd, int k,
                          logic [63:0] e32, logic [63:0] e64, bit m32, bit m64);
      bit we;
      in_valid  = 1'b1; rd_sel = RD_WR_DRAM; rd_en = en; rd_addr = rd;
      ld_sel    = op; ld_addr = addr;
      rsp_valid = 1'($urandom % 2); rsp_data = ~rsp;   // ignored in the accept cycle
      @(negedge clk);
      for (int c = 1; c <= TO; c++) begin
         for (int w = 0; w < 2; w++) check_one({tag, ".wait"}, w, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
         // Junk ALU requests while busy must not be accepted.
         in_valid  = 1'($urandom % 2); rd_sel = RD_WR_ALU; rd_en = 1'b1; rd_addr = 5'd3;
         alu       = {$urandom, $urandom};
         rsp_valid = (c == k);
         rsp_data  = (c == k) ? rsp : {$urandom, $urandom};
         @(negedge clk);
         if (c == k) break;
      end
      in_valid  = 1'b0; rsp_valid = 1'b0;
      if (k == 0) begin
         for (int w = 0; w < 2; w++) check_one({tag, ".tmo"}, w, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 64'd0);
      end else begin
         we = en && (rd != 5'd0);
         check_one(tag, 0, 1'b1, we && !m32, m32, 1'b0, rd, e32);
         check_one(tag, 1, 1'b1, we && !m64, m64, 1'b0, rd, e64);
      end
   endtask

   initial begin
      logic [63:0] r, e32, e64;
      logic [2:0]  op, ad;
      bit          m32, m64;

      //          op          addr  rsp                     k   e32                     e64                     m32 m64
      vecs[0]  = '{DRAM_RD_B,  3'd3, 64'h0000_0000_80FF_FF01, 1, 64'h0000_0000_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 0, 0};
      vecs[1]  = '{DRAM_RD_BU, 3'd3, 64'h0000_0000_80FF_FF01, 2, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080, 0, 0};
      vecs[2]  = '{DRAM_RD_HU, 3'd2, 64'h0000_0000_80FF_FF01, 1, 64'h0000_0000_0000_80FF, 64'h0000_0000_0000_80FF, 0, 0};
      vecs[3]  = '{DRAM_RD_WU, 3'd4, 64'hDEAD_BEEF_0000_0001, 3, 64'h0000_0000_0000_0000, 64'h0000_0000_DEAD_BEEF, 0, 0};
      vecs[4]  = '{DRAM_RD_W,  3'd4, 64'hDEAD_BEEF_0000_0001, 1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0};
      vecs[5]  = '{DRAM_RD_D,  3'd0, 64'h0123_4567_89AB_CDEF, 2, 64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF, 0, 0};
      vecs[6]  = '{DRAM_RD_H,  3'd1, 64'h0000_0000_0000_1234, 3, 64'h0,                   64'h0,                   1, 1};
      vecs[7]  = '{DRAM_RD_D,  3'd4, 64'h1111_2222_3333_4444, 1, 64'h0000_0000_0000_0000, 64'h0,                   0, 1};
      vecs[8]  = '{3'd7,       3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 0, 0};
      vecs[9]  = '{DRAM_RD_HU, 3'd6, 64'hABCD_0000_0000_1234, 4, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_ABCD, 0, 0};
      vecs[10] = '{DRAM_RD_W,  3'd0, 64'h5555_5555_5555_5555, 0, 64'h0,                   64'h0,                   0, 0};

      in_valid = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_sel = '0; ld_sel = '0; ld_addr = '0;
      pc = '0; alu = '0; rsp_valid = 1'b0; rsp_data = '0;
      hold_addr = '{default: '0};
      hold_data = '{default: '0};

      repeat (2) @(negedge clk);
      for (int w = 0; w < 2; w++) check_one("reset", w, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_alu("alu_rd5", RD_WR_ALU, 1'b1, 5'd5, 64'h0000_0000_1234_5678, 64'h0);
      do_alu("alu_rd0", RD_WR_ALU, 1'b1, 5'd0, 64'h0000_0000_CAFE_F00D, 64'h0);
      do_alu("pc_next", RD_WR_PC_NEXT, 1'b1, 5'd1, 64'hAAAA, 64'h8765_4321_0000_0044);
      do_alu("sel_unused", 2'd3, 1'b1, 5'd2, 64'h1234, 64'h5678);
      do_alu("en_low", RD_WR_ALU, 1'b0, 5'd4, 64'h9999, 64'h0);

      for (int i = 0; i < 11; i++)
         do_load($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rsp, 1'b1, 5'd7,
                 vecs[i].k, vecs[i].e32, vecs[i].e64, vecs[i].m32, vecs[i].m64);

      // Load completion followed directly by an ALU accept: strobes on consecutive cycles.
      do_load("b2b_ld", DRAM_RD_BU, 3'd1, 64'h0000_0000_0000_AB00, 1'b1, 5'd10, 1,
              64'hAB, 64'hAB, 1'b0, 1'b0);
      do_alu("b2b_alu", RD_WR_ALU, 1'b1, 5'd11, 64'h0000_0000_0BAD_CAFE, 64'h0);

      // Reset in the middle of WAIT, then a late response.
      in_valid = 1'b1; rd_sel = RD_WR_DRAM; rd_en = 1'b1; rd_addr = 5'd9;
      ld_sel = DRAM_RD_W; ld_addr = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      hold_addr = '{default: '0};
      hold_data = '{default: '0};
      for (int w = 0; w < 2; w++) check_one("rst_wait", w, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      @(negedge clk);
      rst_n = 1'b1; rsp_valid = 1'b1; rsp_data = 64'h7777_7777_7777_7777;
      @(negedge clk);
      rsp_valid = 1'b0;
      for (int w = 0; w < 2; w++) check_one("late_rsp", w, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);

      // Random mix against the reference model.
      for (int i = 0; i < 150; i++) begin
         if ($urandom % 3 == 0) begin
            logic [1:0] s;
            case ($urandom % 3)
               0:       s = RD_WR_ALU;
               1:       s = RD_WR_PC_NEXT;
               default: s = 2'd3;
            endcase
            do_alu($sformatf("rnd%0d", i), s, 1'($urandom % 4 != 0), 5'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom});
         end else begin
            op  = 3'($urandom);
            ad  = 3'($urandom);
            r   = {$urandom, $urandom};
            e32 = ref_load(32, op, ad, r, m32);
            e64 = ref_load(64, op, ad, r, m64);
            do_load($sformatf("rnd%0d", i), op, ad, r, 1'($urandom % 4 != 0), 5'($urandom),
                    $urandom_range(0, TO), e32, e64, m32, m64);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
